// File: rtl/maze_solver_if.sv
// Memory bus and path stream between the maze solver, the one-bit maze memory
// and the downstream path consumer.
interface maze_solver_if #(
    parameter int COORD_W = 4
);
    logic [COORD_W-1:0] X;
    logic [COORD_W-1:0] Y;
    logic               RD;
    logic               WR;
    logic               D_in;
    logic               D_out;
    logic               out_valid;
    logic               out_ready;
    logic [COORD_W-1:0] out_x;
    logic [COORD_W-1:0] out_y;

    modport master (
        output X, Y, RD, WR, D_in,
        input  D_out,
        output out_valid, out_x, out_y,
        input  out_ready
    );

    modport slave (
        input  X, Y, RD, WR, D_in,
        output D_out,
        input  out_valid, out_x, out_y,
        output out_ready
    );
endinterface

// File: rtl/maze_solver.sv
// Depth-first maze solver: walks from (0,0) to the goal, marking visited cells
// in the maze memory, backtracking through a coordinate stack, and streaming
// the found path start-to-goal over a valid/ready port.
module maze_solver #(
    parameter int COORD_W     = 4,
    parameter int STACK_DEPTH = 256,
    parameter int GOAL_X      = 15,
    parameter int GOAL_Y      = 15
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    maze_solver_if.master bus,
    output logic         busy,
    output logic         done,
    output logic         fail,
    output logic [8:0]   path_len
);
    localparam int AW   = $clog2(STACK_DEPTH);
    localparam int SP_W = $clog2(STACK_DEPTH + 1);
    localparam logic [COORD_W-1:0] C_MAX   = {COORD_W{1'b1}};
    localparam logic [COORD_W-1:0] GX      = COORD_W'(GOAL_X);
    localparam logic [COORD_W-1:0] GY      = COORD_W'(GOAL_Y);
    localparam logic [SP_W-1:0]    SP_FULL = SP_W'(STACK_DEPTH);
    localparam logic [SP_W-1:0]    SP_ONE  = SP_W'(1);

    typedef enum logic [3:0] {
        IDLE, RD_START, CHK_START, MARK, PROBE, EVAL, BACK, DONE_OUT, FAIL
    } state_t;

    state_t state, state_next;

    logic [COORD_W-1:0] stack_x   [STACK_DEPTH];
    logic [COORD_W-1:0] stack_y   [STACK_DEPTH];
    logic [1:0]         stack_dir [STACK_DEPTH];

    logic [SP_W-1:0]    sp, idx;
    logic [COORD_W-1:0] cur_x, cur_y, nbr_x, nbr_y;
    logic [1:0]         dir;
    logic               nbr_ok, at_goal, xfer, last_beat;
    logic [AW-1:0]      push_ptr, top_ptr, prev_ptr, idx_ptr;

    assign push_ptr  = sp[AW-1:0];
    assign top_ptr   = AW'(sp - SP_ONE);
    assign prev_ptr  = AW'(sp - SP_W'(2));
    assign idx_ptr   = idx[AW-1:0];
    assign at_goal   = (cur_x == GX) && (cur_y == GY);
    assign xfer      = bus.out_valid && bus.out_ready;
    assign last_beat = (idx == sp - SP_ONE);

    assign bus.D_in      = 1'b1;
    assign bus.out_valid = (state == DONE_OUT);
    assign bus.out_x     = bus.out_valid ? stack_x[idx_ptr] : '0;
    assign bus.out_y     = bus.out_valid ? stack_y[idx_ptr] : '0;
    assign busy          = (state != IDLE) && (state != DONE_OUT) && (state != FAIL);

    // Neighbour of the current top cell in the direction being tried; edges never wrap.
    always_comb begin
        nbr_x  = cur_x;
        nbr_y  = cur_y;
        nbr_ok = 1'b0;
        case (dir)
            2'd0: begin nbr_ok = (cur_x != C_MAX); nbr_x = cur_x + 1'b1; end
            2'd1: begin nbr_ok = (cur_y != C_MAX); nbr_y = cur_y + 1'b1; end
            2'd2: begin nbr_ok = (cur_x != '0);    nbr_x = cur_x - 1'b1; end
            default: begin nbr_ok = (cur_y != '0); nbr_y = cur_y - 1'b1; end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state decode and memory bus strobes; RD and WR come from disjoint states.
    always_comb begin
        state_next = state;
        bus.RD     = 1'b0;
        bus.WR     = 1'b0;
        bus.X      = '0;
        bus.Y      = '0;
        case (state)
            IDLE:      if (start) state_next = RD_START;
            RD_START: begin
                bus.RD     = 1'b1;
                state_next = CHK_START;
            end
            CHK_START: state_next = bus.D_out ? FAIL : MARK;
            MARK: begin
                bus.WR = 1'b1;
                bus.X  = cur_x;
                bus.Y  = cur_y;
                if (sp == SP_FULL) state_next = FAIL;
                else if (at_goal)  state_next = DONE_OUT;
                else               state_next = PROBE;
            end
            PROBE: begin
                if (nbr_ok) begin
                    bus.RD     = 1'b1;
                    bus.X      = nbr_x;
                    bus.Y      = nbr_y;
                    state_next = EVAL;
                end else if (dir == 2'd3) begin
                    state_next = BACK;
                end
            end
            EVAL: begin
                if (!bus.D_out)         state_next = MARK;
                else if (dir == 2'd3)   state_next = BACK;
                else                    state_next = PROBE;
            end
            BACK: begin
                if (sp == SP_ONE)                     state_next = FAIL;
                else if (stack_dir[prev_ptr] == 2'd3) state_next = BACK;
                else                                  state_next = PROBE;
            end
            DONE_OUT:  if (xfer && last_beat) state_next = IDLE;
            FAIL:      state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // Stack storage: push on MARK, remember the winning direction when a move is taken.
    always_ff @(posedge clk) begin
        if (state == MARK && sp != SP_FULL) begin
            stack_x[push_ptr]   <= cur_x;
            stack_y[push_ptr]   <= cur_y;
            stack_dir[push_ptr] <= 2'd0;
        end else if (state == EVAL && !bus.D_out) begin
            stack_dir[top_ptr] <= dir;
        end
    end

    // Search datapath: current cell, direction, stack pointer, result flags and stream index.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sp       <= '0;
            idx      <= '0;
            cur_x    <= '0;
            cur_y    <= '0;
            dir      <= 2'd0;
            done     <= 1'b0;
            fail     <= 1'b0;
            path_len <= '0;
        end else begin
            if (state != FAIL && state_next == FAIL) fail <= 1'b1;
            case (state)
                IDLE: begin
                    if (start) begin
                        done     <= 1'b0;
                        fail     <= 1'b0;
                        path_len <= '0;
                        sp       <= '0;
                        idx      <= '0;
                        cur_x    <= '0;
                        cur_y    <= '0;
                        dir      <= 2'd0;
                    end
                end
                MARK: begin
                    if (sp != SP_FULL) begin
                        sp  <= sp + SP_ONE;
                        dir <= 2'd0;
                        if (at_goal) begin
                            done     <= 1'b1;
                            path_len <= 9'(sp) + 9'd1;
                        end
                    end
                end
                PROBE: if (!nbr_ok && dir != 2'd3) dir <= dir + 2'd1;
                EVAL: begin
                    if (!bus.D_out) begin
                        cur_x <= nbr_x;
                        cur_y <= nbr_y;
                    end else if (dir != 2'd3) begin
                        dir <= dir + 2'd1;
                    end
                end
                BACK: begin
                    sp <= sp - SP_ONE;
                    if (sp != SP_ONE) begin
                        cur_x <= stack_x[prev_ptr];
                        cur_y <= stack_y[prev_ptr];
                        dir   <= stack_dir[prev_ptr] + 2'd1;
                    end
                end
                DONE_OUT: if (xfer) idx <= idx + SP_ONE;
                FAIL:     path_len <= '0;
                default:  ;
            endcase
        end
    end
endmodule
